// File: rtl/tank_motion_controller.sv
`default_nettype none
// ============================================================================
// Module   : tank_motion_controller
// Purpose  : Per-frame sprite motion with playfield clamping, plus a fire
//            request/acknowledge handshake followed by a frame-counted cooldown.
// Revision : 1.0  initial release
// ============================================================================
module tank_motion_controller #(
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 623,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 463,
    parameter int START_X         = 320,
    parameter int START_Y         = 240,
    parameter int STEP            = 2,
    parameter int COOLDOWN_FRAMES = 30
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic [1:0] orientation,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       moving,
    output logic       fire_req,
    input  logic       fire_ack,
    output logic [1:0] fire_dir,
    output logic [9:0] fire_x,
    output logic [9:0] fire_y,
    output logic       cooldown_active
);

    localparam logic [7:0]  C_KEY_LEFT  = 8'h04;
    localparam logic [7:0]  C_KEY_RIGHT = 8'h07;
    localparam logic [7:0]  C_KEY_DOWN  = 8'h16;
    localparam logic [7:0]  C_KEY_UP    = 8'h1A;
    localparam logic [7:0]  C_KEY_FIRE  = 8'h2C;
    localparam logic [10:0] C_STEP      = 11'(STEP);
    localparam logic [10:0] C_X_MIN     = 11'(X_MIN);
    localparam logic [10:0] C_X_MAX     = 11'(X_MAX);
    localparam logic [10:0] C_Y_MIN     = 11'(Y_MIN);
    localparam logic [10:0] C_Y_MAX     = 11'(Y_MAX);
    localparam logic [7:0]  C_COOLDOWN  = 8'(COOLDOWN_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FIRE_REQ = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic       moving_q, moving_d;
    logic [1:0] fire_dir_q, fire_dir_d;
    logic [9:0] fire_x_q, fire_x_d;
    logic [9:0] fire_y_q, fire_y_d;
    logic [7:0] cnt_q, cnt_d;

    // 11-bit arithmetic so a step past either bound cannot wrap before clamping
    function automatic logic [9:0] step_up(input logic [9:0] p, input logic [10:0] lim);
        logic [10:0] s;
        s = {1'b0, p} + C_STEP;
        return (s > lim) ? lim[9:0] : s[9:0];
    endfunction

    function automatic logic [9:0] step_down(input logic [9:0] p, input logic [10:0] lim);
        logic [10:0] s;
        s = {1'b0, p} - C_STEP;
        return ({1'b0, p} < (lim + C_STEP)) ? lim[9:0] : s[9:0];
    endfunction

    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        moving_d = moving_q;
        if (frame_tick) begin
            case (keycode)
                C_KEY_LEFT:  pos_x_d = step_down(pos_x_q, C_X_MIN);
                C_KEY_RIGHT: pos_x_d = step_up(pos_x_q, C_X_MAX);
                C_KEY_DOWN:  pos_y_d = step_up(pos_y_q, C_Y_MAX);
                C_KEY_UP:    pos_y_d = step_down(pos_y_q, C_Y_MIN);
                default:     ;
            endcase
            moving_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fire_dir_d      = fire_dir_q;
        fire_x_d        = fire_x_q;
        fire_y_d        = fire_y_q;
        fire_req        = 1'b0;
        cooldown_active = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Fire key cannot also be a movement key, so pos_*_q is the pre-move value
                if (frame_tick && (keycode == C_KEY_FIRE)) begin
                    state_d    = S_FIRE_REQ;
                    fire_dir_d = orientation;
                    fire_x_d   = pos_x_q;
                    fire_y_d   = pos_y_q;
                end
            end
            S_FIRE_REQ: begin
                fire_req = 1'b1;
                if (fire_ack) begin
                    state_d = S_COOLDOWN;
                    cnt_d   = C_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                cooldown_active = 1'b1;
                if (frame_tick) begin
                    if (cnt_q <= 8'd1) begin
                        state_d = S_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_IDLE;
            pos_x_q    <= 10'(START_X);
            pos_y_q    <= 10'(START_Y);
            moving_q   <= 1'b0;
            fire_dir_q <= 2'b00;
            fire_x_q   <= 10'd0;
            fire_y_q   <= 10'd0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            moving_q   <= moving_d;
            fire_dir_q <= fire_dir_d;
            fire_x_q   <= fire_x_d;
            fire_y_q   <= fire_y_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pos_x    = pos_x_q;
    assign pos_y    = pos_y_q;
    assign moving   = moving_q;
    assign fire_dir = fire_dir_q;
    assign fire_x   = fire_x_q;
    assign fire_y   = fire_y_q;

endmodule
`default_nettype wire

// File: doc/tank_motion_controller.md
Name: tank_motion_controller

Overview:
Per-frame motion and fire sequencer for the player sprite. It samples the keyboard keycode once per video frame and steps the sprite position inside a bounded playfield. It also runs a fire request/acknowledge handshake with the projectile unit, followed by a cooldown. It sits between the USB keycode register, the orientation state machine (which supplies the facing direction) and the sprite/projectile drawing logic.

Parameters:
X_MIN, 0, leftmost legal pos_x
X_MAX, 623, rightmost legal pos_x
Y_MIN, 0, topmost legal pos_y
Y_MAX, 463, bottommost legal pos_y
START_X, 320, pos_x after reset
START_Y, 240, pos_y after reset
STEP, 2, pixels moved per frame_tick
COOLDOWN_FRAMES, 30, frame_ticks between shots (1..255)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-Clk pulse per frame (vsync edge)
keycode  in  8  current USB keycode; 0x00 means no key
orientation  in  2  facing direction: 00 left, 01 right, 10 down, 11 up
pos_x  out  10  sprite X position
pos_y  out  10  sprite Y position
moving  out  1  position changed on the last frame_tick
fire_req  out  1  projectile launch request
fire_ack  in  1  projectile unit accepts request
fire_dir  out  2  launch direction, latched
fire_x  out  10  launch X, latched
fire_y  out  10  launch Y, latched
cooldown_active  out  1  high while in COOLDOWN

Behaviour:
- Interface: one clock, Clk. Reset_n is asynchronous and active-low. All state is clocked on the Clk rising edge.
- Reset values: pos_x=START_X, pos_y=START_Y, moving=0, fire_req=0, fire_dir=00, fire_x=0, fire_y=0, cooldown_active=0, state=IDLE, cooldown counter=0.
- Reset asserted at any time, including mid-handshake, drops fire_req immediately. No pending shot survives reset.
- keycode is evaluated only in the cycle where frame_tick=1. It is ignored in all other cycles.
- Movement on frame_tick, with direction decoded from keycode directly, not from orientation:
  - 0x04: pos_x -= STEP.
  - 0x07: pos_x += STEP.
  - 0x16: pos_y += STEP.
  - 0x1A: pos_y -= STEP.
  - Any other key: no movement.
- Movement is updated one cycle after the tick, and proceeds in every FSM state.
- Clamping, using 11-bit intermediates so there is no wrap:
  - If pos+STEP > MAX, result = MAX.
  - If pos < MIN+STEP, result = MIN.
  - An axis already at its bound stays there.
- moving is updated on every frame_tick: 1 if pos_x or pos_y actually changed, else 0 (this includes a clamped move with no change). It holds its value between ticks.
- FSM states: IDLE, FIRE_REQ, COOLDOWN.
  - IDLE -> FIRE_REQ: on frame_tick with keycode==0x2C. On entry, fire_dir<=orientation, fire_x<=pos_x, fire_y<=pos_y. The latch uses pre-move values (no movement key is possible in that cycle).
  - FIRE_REQ: fire_req=1. fire_dir, fire_x and fire_y stay stable until acknowledged. frame_ticks do not abort the request.
  - FIRE_REQ -> COOLDOWN: on the first cycle with fire_ack=1. The counter is loaded with COOLDOWN_FRAMES and fire_req deasserts the next cycle.
  - COOLDOWN: cooldown_active=1. The counter decrements on each frame_tick. On the frame_tick where the counter is 1, go to IDLE. A 0x2C on that same tick is ignored; the next tick can fire.
  - Holding 0x2C continuously fires again on the first tick in IDLE, giving a period of COOLDOWN_FRAMES+1 ticks plus ack latency.
- fire_ack outside FIRE_REQ is ignored.
- fire_ack on the same cycle fire_req first rises is accepted (one-cycle handshake).

Test Plan:
1. Reset then release Reset_n -> pos=(320,240), fire_req=0, moving=0, cooldown_active=0; assert Reset_n low mid-cycle -> outputs reset without a Clk edge.
2. keycode=0x07 for 3 frame_ticks -> pos_x 322, 324, 326; moving=1; keycode=0x00 on the next tick -> moving=0, pos unchanged.
3. pos_x=1, keycode=0x04 on a tick -> pos_x=0; another tick -> pos_x=0, moving=0. pos_y=462, keycode=0x16 -> pos_y=463.
4. orientation=11, pos=(100,50), keycode=0x2C on a tick -> fire_req=1, fire_dir=11, fire_x=100, fire_y=50; hold fire_ack=0 for 5 ticks -> request held stable; pulse fire_ack -> fire_req=0, cooldown_active=1.
5. COOLDOWN_FRAMES=3, 0x2C held continuously with immediate ack -> cooldown_active high for exactly 3 frame_ticks; the second fire_req rises on the 4th tick after the ack.
6. Reset_n low while fire_req=1 -> fire_req=0 and state=IDLE; a stray fire_ack in IDLE -> no state change.
